// File: rtl/display_7s_scan_pkg.sv
// Shared definitions for the 7-segment scan driver: digit field layout,
// frame geometry, slot state encoding and an anode decode helper.
package display_7s_scan_pkg;

  localparam int DIGITS      = 8;
  localparam int DIGIT_W     = 10;
  localparam int FRAME_W     = DIGITS * DIGIT_W;
  localparam int DIGIT_IDX_W = 3;
  localparam int SEG_W       = 7;
  localparam int BRIGHT_W    = 4;

  // Bit offsets inside one 10-bit digit field
  localparam int F_BLINK   = 9;
  localparam int F_EN      = 8;
  localparam int F_DP      = 7;
  localparam int F_SEG_MSB = 6;
  localparam int F_SEG_LSB = 0;

  // Packed view of one digit field; member order matches the offsets above
  typedef struct packed {
    logic             blink;
    logic             en;
    logic             dp;
    logic [SEG_W-1:0] seg;
  } digit_field_t;

  // Phase of the current digit slot
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } slot_state_t;

  // Active-low anode pattern with exactly one anode enabled
  function automatic logic [DIGITS-1:0] anode_sel_n(input logic [DIGIT_IDX_W-1:0] idx);
    logic [DIGITS-1:0] m;
    m      = '1;
    m[idx] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/display_7s_scan_if.sv
// Content/pin bundle between the display content source, the scan driver
// and the board pins.
interface display_7s_scan_if;
  import display_7s_scan_pkg::*;

  logic [FRAME_W-1:0]  dis_data;
  logic [BRIGHT_W-1:0] brightness;
  logic [DIGITS-1:0]   an;
  logic [SEG_W-1:0]    seg;
  logic                dp;
  logic                frame_start;

  // Content source side: supplies frame data, observes pins and frame strobe
  modport master (
    output dis_data,
    output brightness,
    input  an,
    input  seg,
    input  dp,
    input  frame_start
  );

  // Scan driver side
  modport slave (
    input  dis_data,
    input  brightness,
    output an,
    output seg,
    output dp,
    output frame_start
  );

endinterface

// File: rtl/display_7s_scan_timebase.sv
// Slot timebase: cycle counter within a digit slot, digit index, and the
// registered BLANK/ON slot state, plus the strobes derived from them.
import display_7s_scan_pkg::*;

module display_7s_scan_timebase #(
  parameter int DIGIT_PERIOD_CYCLES = 100000,
  parameter int BLANK_CYCLES        = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [DIGIT_IDX_W-1:0] digit_o,
  output logic                   blank_o,
  output logic                   on_o,
  output logic                   slot_start_o,
  output logic                   frame_start_o,
  output logic                   frame_end_o
);

  localparam int CNT_W = (DIGIT_PERIOD_CYCLES > 1) ? $clog2(DIGIT_PERIOD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  // A slot only starts in ON when no blanking gap is configured
  localparam slot_state_t ST_RESET = (BLANK_CYCLES > 0) ? ST_BLANK : ST_ON;

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DIGIT_IDX_W-1:0] digit_q, digit_d;
  slot_state_t            state_q, state_d;
  logic                   cnt_wrap;

  // Next counter/digit values; the slot state is derived from the next count
  // so that state_q always agrees with cnt_q in the same cycle
  always_comb begin
    cnt_wrap = (cnt_q == CNT_LAST);
    cnt_d    = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
    digit_d  = cnt_wrap ? digit_q + DIGIT_IDX_W'(1) : digit_q;
    state_d  = (cnt_d < BLANK_END) ? ST_BLANK : ST_ON;
  end

  // Slot counter, digit index and slot FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      digit_q <= '0;
      state_q <= ST_RESET;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      state_q <= state_d;
    end
  end

  assign digit_o       = digit_q;
  assign blank_o       = (state_q == ST_BLANK);
  assign on_o          = (state_q == ST_ON);
  assign slot_start_o  = (cnt_q == '0);
  assign frame_start_o = (cnt_q == '0) && (digit_q == '0);
  assign frame_end_o   = cnt_wrap && (digit_q == DIGIT_IDX_W'(DIGITS - 1));

endmodule

// File: rtl/display_7s_scan.sv
// 8-digit time-multiplexed 7-segment scan driver. Latches a whole frame at
// the start of each scan so content never tears, blanks the first part of
// every digit slot against ghosting, and applies per-digit enable/blink and
// a global PWM brightness. All pins are registered, active-low.
import display_7s_scan_pkg::*;

module display_7s_scan #(
  parameter int DIGIT_PERIOD_CYCLES = 100000,
  parameter int BLANK_CYCLES        = 1000,
  parameter int BLINK_FRAMES        = 62
) (
  input  logic               clk,
  input  logic               reset,
  display_7s_scan_if.slave   bus
);

  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  logic [DIGIT_IDX_W-1:0] digit;
  logic                   blank;
  logic                   on;
  logic                   slot_start;
  logic                   frame_latch;
  logic                   frame_end;

  display_7s_scan_timebase #(
    .DIGIT_PERIOD_CYCLES (DIGIT_PERIOD_CYCLES),
    .BLANK_CYCLES        (BLANK_CYCLES)
  ) u_timebase (
    .clk           (clk),
    .reset         (reset),
    .digit_o       (digit),
    .blank_o       (blank),
    .on_o          (on),
    .slot_start_o  (slot_start),
    .frame_start_o (frame_latch),
    .frame_end_o   (frame_end)
  );

  logic [FRAME_W-1:0]  frame_q;
  logic [BRIGHT_W-1:0] bright_q;
  logic [BRIGHT_W-1:0] pwm_q, pwm_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                frame_start_q;
  logic                lit;
  digit_field_t        cur;
  digit_field_t        field [DIGITS];

  // Per-digit views of the latched frame buffer
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_field
    assign field[gi] = digit_field_t'(frame_q[gi*DIGIT_W +: DIGIT_W]);
  end

  // Blink counter advances as each frame completes, so the first
  // BLINK_FRAMES frames after reset share phase 0
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_end) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  // PWM ramp restarts at every ON phase and free-runs through it; pin decode
  // for the current digit
  always_comb begin
    pwm_d = (on && !slot_start) ? pwm_q + BRIGHT_W'(1) : '0;
    cur   = field[digit];
    lit   = !blank && cur.en && !(cur.blink && blink_phase_q) && (pwm_q <= bright_q);
    an_d  = lit ? anode_sel_n(digit) : '1;
    seg_d = lit ? ~cur.seg : '1;
    dp_d  = lit ? ~cur.dp : 1'b1;
  end

  // Frame/brightness latch, blink state, PWM and registered pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q       <= '0;
      bright_q      <= '0;
      pwm_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      an_q          <= '1;
      seg_q         <= '1;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      if (frame_latch) begin
        frame_q  <= bus.dis_data;
        bright_q <= bus.brightness;
      end
      frame_start_q <= frame_latch;
      pwm_q         <= pwm_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_display_7s_scan.sv
// Directed bench for display_7s_scan with a short slot (20 cycles, 4 blank)
// and a 2-frame blink half-period. Pins are sampled on the falling edge;
// cycle k is the state after the k-th rising edge following reset release.
module tb_display_7s_scan;
  import display_7s_scan_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  display_7s_scan_if bus ();

  display_7s_scan #(
    .DIGIT_PERIOD_CYCLES (20),
    .BLANK_CYCLES        (4),
    .BLINK_FRAMES        (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Hold reset for two cycles, check the reset pin state, release on a falling edge
  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_rst_an"},  int'(bus.an),  'hFF);
    check({tag, "_rst_seg"}, int'(bus.seg), 'h7F);
    check({tag, "_rst_dp"},  int'(bus.dp),  1);
    check({tag, "_rst_fs"},  int'(bus.frame_start), 0);
    reset = 1'b0;
    cyc   = 0;
  endtask

  // Run n cycles: count cycles with an == an_exp, cycles with any other anode
  // low, and lit cycles whose segments differ from seg_exp
  task automatic scan(input int n, input int an_exp, input int seg_exp,
                      output int hits, output int stray, output int seg_bad);
    hits = 0; stray = 0; seg_bad = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (int'(bus.an) == an_exp) begin
        hits++;
        if (int'(bus.seg) != seg_exp) seg_bad++;
      end else if (bus.an != 8'hFF) begin
        stray++;
      end
    end
  endtask

  function automatic logic [FRAME_W-1:0] put(input logic [FRAME_W-1:0] f, input int idx,
                                             input logic [DIGIT_W-1:0] v);
    f[idx*DIGIT_W +: DIGIT_W] = v;
    return f;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, s, b;
    int exp_blink [6] = '{16, 16, 0, 0, 16, 16};

    bus.dis_data   = '0;
    bus.brightness = '0;

    // Reset release, digit 0 = 0x13F at full brightness, mid-frame content change
    $display("test 1-3: reset release, digit0 scan, no tearing");
    bus.dis_data   = put('0, 0, 10'h13F);
    bus.brightness = 4'd15;
    do_reset("t1");
    step();
    check("t1_fs_c1", int'(bus.frame_start), 1);
    check("t1_an_c1", int'(bus.an), 'hFF);
    for (int k = 2; k <= 4; k++) begin
      step();
      check("t1_fs_blank", int'(bus.frame_start), 0);
      check("t1_an_blank", int'(bus.an), 'hFF);
      check("t1_seg_blank", int'(bus.seg), 'h7F);
      check("t1_dp_blank", int'(bus.dp), 1);
    end
    for (int k = 5; k <= 10; k++) begin
      step();
      check("t2_an_d0", int'(bus.an), 'hFE);
      check("t2_seg_d0", int'(bus.seg), 'h40);
      check("t2_dp_d0", int'(bus.dp), 1);
    end
    bus.dis_data = put('0, 0, 10'h106);
    for (int k = 11; k <= 20; k++) begin
      step();
      check("t3_an_hold", int'(bus.an), 'hFE);
      check("t3_seg_hold", int'(bus.seg), 'h40);
    end
    scan(140, 'hFE, 'h40, h, s, b);
    check("t2_d1_7_dark", h, 0);
    check("t2_d1_7_stray", s, 0);
    step();
    check("t3_fs_c161", int'(bus.frame_start), 1);
    check("t3_an_c161", int'(bus.an), 'hFF);
    scan(3, 'hFE, 'h79, h, s, b);
    check("t3_blank_c162_164", h + s, 0);
    scan(16, 'hFE, 'h79, h, s, b);
    check("t3_new_lit", h, 16);
    check("t3_new_seg", b, 0);

    // Blinking digit 3: lit in frames 0-1 and 4-5, dark in frames 2-3
    $display("test 4: blink on digit 3");
    bus.dis_data   = put('0, 3, 10'h306);
    bus.brightness = 4'd15;
    do_reset("t4");
    for (int f = 0; f < 6; f++) begin
      scan(160, 'hF7, 'h79, h, s, b);
      check($sformatf("t4_lit_f%0d", f), h, exp_blink[f]);
      check($sformatf("t4_stray_f%0d", f), s, 0);
      check($sformatf("t4_seg_f%0d", f), b, 0);
    end

    // PWM: brightness 3 gives 4 lit cycles; 0 gives 1, taking effect next frame
    $display("test 5: pwm brightness");
    bus.dis_data   = put('0, 0, 10'h101);
    bus.brightness = 4'd3;
    do_reset("t5");
    repeat (4) step();
    step();
    check("t5_an_c5", int'(bus.an), 'hFE);
    check("t5_seg_c5", int'(bus.seg), 'h7E);
    step();
    check("t5_an_c6", int'(bus.an), 'hFE);
    bus.brightness = 4'd0;
    scan(14, 'hFE, 'h7E, h, s, b);
    check("t5_b3_rest", h, 2);
    scan(140, 'hFE, 'h7E, h, s, b);
    check("t5_d1_7_dark", h + s, 0);
    scan(4, 'hFE, 'h7E, h, s, b);
    check("t5_b0_blank", h, 0);
    step();
    check("t5_b0_an_c165", int'(bus.an), 'hFE);
    scan(15, 'hFE, 'h7E, h, s, b);
    check("t5_b0_rest", h, 0);

    // Async reset during digit 5 ON, then restart from digit 0 with a relatched frame
    $display("test 6: reset mid-scan");
    bus.dis_data   = put('0, 5, 10'h17F);
    bus.brightness = 4'd15;
    do_reset("t6a");
    scan(109, 'hDF, 'h00, h, s, b);
    check("t6_d5_pre_hits", h, 5);
    check("t6_d5_pre_stray", s, 0);
    step();
    check("t6_an_c110", int'(bus.an), 'hDF);
    check("t6_seg_c110", int'(bus.seg), 'h00);
    reset = 1'b1;
    #1;
    check("t6_async_an", int'(bus.an), 'hFF);
    check("t6_async_seg", int'(bus.seg), 'h7F);
    check("t6_async_dp", int'(bus.dp), 1);
    bus.dis_data = put('0, 5, 10'h140);
    do_reset("t6b");
    step();
    check("t6_fs_c1", int'(bus.frame_start), 1);
    scan(103, 'hDF, 'h3F, h, s, b);
    check("t6_restart_dark", h + s, 0);
    step();
    check("t6_an_c105", int'(bus.an), 'hDF);
    check("t6_seg_c105", int'(bus.seg), 'h3F);
    scan(15, 'hDF, 'h3F, h, s, b);
    check("t6_d5_hits", h, 15);
    check("t6_d5_seg", b, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
